// File: rtl/srl_chain_checker.sv
// Built-in self-test for a cascade of N SRL32 shift registers: fills the chain with an
// LFSR pattern, then reads every tap back against a shadow model for ROUNDS sweeps.
module srl_chain_checker #(
  parameter int          N      = 1,
  parameter int          ROUNDS = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  output logic                       SRL_CE,
  output logic                       SRL_D,
  output logic [5+$clog2(N)-1:0]     SRL_A,
  input  logic                       SRL_Q,
  input  logic                       SRL_Q31,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERROR,
  output logic [15:0]                ERR_CNT,
  output logic [2:0]                 DBG_STATE
);

  localparam int          LEN      = 32 * N;
  localparam int          AW       = 5 + $clog2(N);
  localparam int          RND      = (ROUNDS == 0) ? 1 : ROUNDS;
  localparam logic [15:0] SEED_V   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [AW-1:0] LAST   = AW'(LEN - 1);
  localparam logic [31:0] RND_LAST = 32'(RND - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SET  = 3'd2,
    S_CHK  = 3'd3,
    S_STEP = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [31:0]     round_cnt;
  logic [15:0]     lfsr;
  logic [LEN-1:0]  model;
  logic [15:0]     err_cnt;

  logic            start_ok;
  logic            fb;
  logic            q_bad;
  logic            q31_bad;
  logic [1:0]      inc;
  logic [16:0]     err_sum;

  // START is a plain level sampled on the rising edge; it is acted on only in IDLE or FIN
  // and silently dropped in every other state (there is no ready/acknowledge).
  assign start_ok  = START && ((state == S_IDLE) || (state == S_FIN));
  assign fb        = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign SRL_D     = lfsr[0];
  assign ERR_CNT   = err_cnt;
  assign DBG_STATE = state;

  always_comb begin
    q_bad   = (SRL_Q != model[addr]);
    q31_bad = (addr == '0) && (SRL_Q31 != model[LEN-1]);
    inc     = {1'b0, q_bad} + {1'b0, q31_bad};
    err_sum = {1'b0, err_cnt} + {15'b0, inc};
  end

  // Pattern source and shadow model move only when the chain itself shifts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr  <= SEED_V;
      model <= '0;
    end else if (start_ok) begin
      lfsr <= SEED_V;
    end else if (SRL_CE) begin
      lfsr  <= {fb, lfsr[15:1]};
      model <= {model[LEN-2:0], lfsr[0]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      addr      <= '0;
      round_cnt <= '0;
      SRL_CE    <= 1'b0;
      SRL_A     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (START) begin
            state     <= S_FILL;
            addr      <= '0;
            round_cnt <= '0;
            err_cnt   <= '0;
            ERROR     <= 1'b0;
            DONE      <= 1'b0;
            BUSY      <= 1'b1;
            SRL_CE    <= 1'b1;
            SRL_A     <= '0;
          end
        end
        // addr doubles as the fill counter so FILL spans exactly LEN shifts.
        S_FILL: begin
          if (addr == LAST) begin
            state  <= S_SET;
            addr   <= '0;
            SRL_CE <= 1'b0;
            SRL_A  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_SET: begin
          state <= S_CHK;
        end
        S_CHK: begin
          if (inc != 2'd0) begin
            ERROR   <= 1'b1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
          end
          if (addr == LAST) begin
            SRL_A <= '0;
            if (round_cnt == RND_LAST) begin
              state <= S_FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              state  <= S_STEP;
              SRL_CE <= 1'b1;
            end
          end else begin
            addr  <= addr + 1'b1;
            SRL_A <= addr + 1'b1;
            state <= S_SET;
          end
        end
        S_STEP: begin
          state     <= S_SET;
          SRL_CE    <= 1'b0;
          round_cnt <= round_cnt + 32'd1;
          addr      <= '0;
          SRL_A     <= '0;
        end
        default: begin
          state  <= S_IDLE;
          SRL_CE <= 1'b0;
          SRL_A  <= '0;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule
